// File: rtl/matrix_pkg.sv
// Shared definitions for the serial matrix encoder and its front-end arbiter.
//   NUMBER_BITS_DEFAULT : default width of one signed matrix element part
//   matrix_t            : 2x2 complex matrix, indexed [row][col][re/im]
//   arb_state_e         : arbiter FSM states
//   rr_wrap_inc         : (value + step) mod n, for operands already below n
package matrix_pkg;

  localparam int unsigned NUMBER_BITS_DEFAULT = 37;

  typedef logic signed [NUMBER_BITS_DEFAULT-1:0] matrix_t [0:1][0:1][0:1];

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_BUSY  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  // value and step are both below n, so one conditional subtract is enough.
  function automatic int unsigned rr_wrap_inc(input int unsigned value,
                                              input int unsigned step,
                                              input int unsigned n);
    int unsigned sum;
    sum = value + step;
    if (sum >= n) sum = sum - n;
    return sum;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
//   req    : request vector, one bit per requester
//   last   : index of the most recent winner; search starts at last+1
//   valid  : at least one request is present
//   winner : index of the first set request found circularly from last+1
module rr_priority_picker
  import matrix_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned LW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic          valid,
  output logic [LW-1:0] winner
);

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    // off walks the circular distance from last; inner loop keeps every
    // req index a constant so no variable-width bit select is needed.
    for (int unsigned off = 1; off <= N; off++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!valid && req[i] &&
            (rr_wrap_inc(32'(last), off % N, N) == i)) begin
          valid  = 1'b1;
          winner = LW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/serial_encoder_arbiter.sv
// Round-robin front end that shares one serial_matrix_encoder between
// NUM_REQUESTERS matrix producers.
//   clk           : rising-edge clock
//   reset         : asynchronous active-low reset
//   req           : per-requester request level, held until its done
//   matrix_in     : per-requester 2x2 complex matrix [req][row][col][re/im]
//   grant         : one-hot owner of the encoder, zero when idle
//   done          : one-cycle pulse to the owner once its matrix has left
//   busy          : registered, high whenever the FSM is not idle
//   enc_matrix    : latched matrix presented to the encoder
//   enc_ready     : start strobe to the encoder
//   enc_available : encoder idle / able to accept
module serial_encoder_arbiter
  import matrix_pkg::*;
#(
  parameter int unsigned NUMBER_BITS    = NUMBER_BITS_DEFAULT,
  parameter int unsigned NUM_REQUESTERS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQUESTERS-1:0]     req,
  input  logic signed [NUMBER_BITS-1:0] matrix_in [NUM_REQUESTERS][0:1][0:1][0:1],
  output logic [NUM_REQUESTERS-1:0]     grant,
  output logic [NUM_REQUESTERS-1:0]     done,
  output logic                          busy,
  output logic signed [NUMBER_BITS-1:0] enc_matrix [0:1][0:1][0:1],
  output logic                          enc_ready,
  input  logic                          enc_available
);

  localparam int unsigned LW = $clog2(NUM_REQUESTERS);

  arb_state_e                    state_q;
  logic [NUM_REQUESTERS-1:0]     grant_q;
  logic [NUM_REQUESTERS-1:0]     done_q;
  logic                          busy_q;
  logic [LW-1:0]                 last_q;
  logic signed [NUMBER_BITS-1:0] enc_matrix_q [0:1][0:1][0:1];

  logic                          pick_valid;
  logic [LW-1:0]                 pick_idx;
  logic [NUM_REQUESTERS-1:0]     grant_d;

  rr_priority_picker #(
    .N (NUM_REQUESTERS)
  ) u_picker (
    .req    (req),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  always_comb begin
    grant_d = NUM_REQUESTERS'(1) << pick_idx;
  end

  // The matrix register is written only on the IDLE->ISSUE edge, so the
  // encoder can read cells from it at any point of its serialization.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      done_q       <= '0;
      busy_q       <= 1'b0;
      last_q       <= LW'(NUM_REQUESTERS - 1);
      enc_matrix_q <= '{default: '0};
    end else begin
      done_q <= '0;
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            state_q      <= ARB_ISSUE;
            grant_q      <= grant_d;
            last_q       <= pick_idx;
            busy_q       <= 1'b1;
            enc_matrix_q <= matrix_in[pick_idx];
          end
        end
        ARB_ISSUE: begin
          if (!enc_available) state_q <= ARB_BUSY;
        end
        ARB_BUSY: begin
          if (enc_available) begin
            state_q <= ARB_DONE;
            done_q  <= grant_q;
          end
        end
        ARB_DONE: begin
          state_q <= ARB_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ARB_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Combinational so the strobe falls in the same cycle the encoder
  // drops available after accepting; it never sees a second start.
  assign enc_ready  = (state_q == ARB_ISSUE) && enc_available;
  assign grant      = grant_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign enc_matrix = enc_matrix_q;

endmodule

// File: tb/tb_serial_encoder_arbiter.sv
`timescale 1ns/1ps
module tb_serial_encoder_arbiter;
  import matrix_pkg::*;

  localparam int unsigned NB = NUMBER_BITS_DEFAULT;
  localparam int unsigned NR = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NR-1:0]        req, grant, done;
  logic                 busy, enc_ready, enc_available;
  logic signed [NB-1:0] matrix_in [NR][0:1][0:1][0:1];
  matrix_t              enc_matrix;

  logic [1:0]           req2, grant2, done2;
  logic                 busy2, enc_ready2, enc_available2;
  logic signed [NB-1:0] matrix_in2 [2][0:1][0:1][0:1];
  matrix_t              enc_matrix2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned idx;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [NR-1:0] req;
    int unsigned   exp_idx;
    int unsigned   acc;
    int unsigned   ser;
  } vec_t;
  vec_t tbl [12];

  serial_encoder_arbiter #(
    .NUMBER_BITS    (NB),
    .NUM_REQUESTERS (NR)
  ) u_dut (
    .clk           (clk),
    .reset         (rst_n),
    .req           (req),
    .matrix_in     (matrix_in),
    .grant         (grant),
    .done          (done),
    .busy          (busy),
    .enc_matrix    (enc_matrix),
    .enc_ready     (enc_ready),
    .enc_available (enc_available)
  );

  serial_encoder_arbiter #(
    .NUMBER_BITS    (NB),
    .NUM_REQUESTERS (2)
  ) u_dut2 (
    .clk           (clk),
    .reset         (rst_n),
    .req           (req2),
    .matrix_in     (matrix_in2),
    .grant         (grant2),
    .done          (done2),
    .busy          (busy2),
    .enc_matrix    (enc_matrix2),
    .enc_ready     (enc_ready2),
    .enc_available (enc_available2)
  );

  // Encoder model: accepts after acc_delay extra ready cycles, then stays
  // unavailable for ser_len cycles while serializing.
  int unsigned acc_delay, ser_len, wcnt, scnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_available <= 1'b1;
      wcnt <= 0;
      scnt <= 0;
    end else if (enc_available) begin
      if (enc_ready) begin
        if (wcnt >= acc_delay) begin
          enc_available <= 1'b0;
          wcnt <= 0;
          scnt <= ser_len;
        end else begin
          wcnt <= wcnt + 1;
        end
      end
    end else if (scnt <= 1) begin
      enc_available <= 1'b1;
    end else begin
      scnt <= scnt - 1;
    end
  end

  int unsigned scnt2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_available2 <= 1'b1;
      scnt2 <= 0;
    end else if (enc_available2) begin
      if (enc_ready2) begin
        enc_available2 <= 1'b0;
        scnt2 <= 3;
      end
    end else if (scnt2 <= 1) begin
      enc_available2 <= 1'b1;
    end else begin
      scnt2 <= scnt2 - 1;
    end
  end

  function automatic logic signed [NB-1:0] cell_val(input int unsigned r, input int unsigned c);
    logic signed [NB-1:0] v;
    v = NB'(r * 16 + c + 1);
    if (r == 3) v = '0 - (v <<< 30);
    return v;
  endfunction

  function automatic logic [NR-1:0] onehot(input int unsigned r);
    return NR'(1) << r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_mat(input string name, input matrix_t m, input int unsigned r);
    for (int unsigned i = 0; i < 2; i++)
      for (int unsigned j = 0; j < 2; j++)
        for (int unsigned k = 0; k < 2; k++)
          chk(name, 64'(m[i][j][k]), 64'(cell_val(r, i * 4 + j * 2 + k)));
  endtask

  task automatic wait_grant(input string name);
    int unsigned t;
    t = 0;
    while (grant == '0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_grant_seen"}, 64'(grant != '0), 64'(1));
  endtask

  task automatic wait_done(input string name);
    int unsigned t;
    t = 0;
    while (done == '0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_done_seen"}, 64'(done != '0), 64'(1));
  endtask

  task automatic wait_ready_low(input string name);
    int unsigned t;
    t = 0;
    while (enc_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_ready_low"}, 64'(enc_ready), 64'(0));
  endtask

  // Scoreboard side: checks each new grant and its latched matrix against
  // the oldest queued expectation, the matrix stays put while granted, and
  // done pulses belong to the current owner and last one cycle.
  initial begin : monitor
    logic [NR-1:0] gprev, dprev;
    int unsigned   cur;
    exp_t          e;
    gprev = '0;
    dprev = '0;
    cur   = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (grant != '0 && gprev == '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_grant", 64'(grant), 64'(0));
          end else begin
            e   = exp_q.pop_front();
            cur = e.idx;
            chk("grant_owner", 64'(grant), 64'(onehot(cur)));
            chk_mat("enc_matrix_latch", enc_matrix, cur);
          end
        end else if (grant != '0) begin
          chk("grant_stable", 64'(grant), 64'(gprev));
          chk_mat("enc_matrix_hold", enc_matrix, cur);
        end
        if (done != '0) begin
          chk("done_owner", 64'(done), 64'(onehot(cur)));
          chk("done_single_cycle", 64'(dprev), 64'(0));
        end
      end
      gprev = grant;
      dprev = done;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    int unsigned   t, seen, cnt;
    logic [NR-1:0] mask;
    logic [NR-1:0] g;
    exp_t          e;

    tbl[0]  = '{4'b0001, 0, 2, 6};
    tbl[1]  = '{4'b1111, 1, 0, 3};
    tbl[2]  = '{4'b1111, 2, 1, 5};
    tbl[3]  = '{4'b1111, 3, 0, 1};
    tbl[4]  = '{4'b1111, 0, 3, 4};
    tbl[5]  = '{4'b1000, 3, 0, 2};
    tbl[6]  = '{4'b1001, 0, 1, 7};
    tbl[7]  = '{4'b1001, 3, 0, 3};
    tbl[8]  = '{4'b0110, 1, 2, 2};
    tbl[9]  = '{4'b0100, 2, 0, 9};
    tbl[10] = '{4'b0101, 0, 1, 1};
    tbl[11] = '{4'b1010, 1, 0, 4};

    for (int unsigned r = 0; r < NR; r++)
      for (int unsigned i = 0; i < 2; i++)
        for (int unsigned j = 0; j < 2; j++)
          for (int unsigned k = 0; k < 2; k++)
            matrix_in[r][i][j][k] = cell_val(r, i * 4 + j * 2 + k);
    for (int unsigned r = 0; r < 2; r++)
      for (int unsigned i = 0; i < 2; i++)
        for (int unsigned j = 0; j < 2; j++)
          for (int unsigned k = 0; k < 2; k++)
            matrix_in2[r][i][j][k] = cell_val(r, i * 4 + j * 2 + k);

    rst_n = 1'b0;
    req = '0;
    req2 = '0;
    acc_delay = 0;
    ser_len = 4;
    repeat (3) @(negedge clk);

    // Reset state
    chk("reset_grant", 64'(grant), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_enc_ready", 64'(enc_ready), 64'(0));
    for (int unsigned i = 0; i < 2; i++)
      for (int unsigned j = 0; j < 2; j++)
        for (int unsigned k = 0; k < 2; k++)
          chk("reset_enc_matrix", 64'(enc_matrix[i][j][k]), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester: ready high until acceptance, done one cycle after
    // available is seen back high, then back to idle.
    acc_delay = 2;
    ser_len = 40;
    e.idx = 0;
    exp_q.push_back(e);
    req = 4'b0001;
    wait_grant("single");
    chk("single_busy", 64'(busy), 64'(1));
    cnt = 0;
    while (enc_ready && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("single_ready_cycles", 64'(cnt), 64'(3));
    t = 0;
    while (!enc_available && t < 200) begin
      chk("single_no_early_done", 64'(done), 64'(0));
      @(negedge clk);
      t++;
    end
    chk("single_avail_back", 64'(enc_available), 64'(1));
    chk("single_done_not_yet", 64'(done), 64'(0));
    @(negedge clk);
    chk("single_done", 64'(done), 64'(4'b0001));
    req = '0;
    @(negedge clk);
    chk("single_idle_grant", 64'(grant), 64'(0));
    chk("single_idle_busy", 64'(busy), 64'(0));
    chk("single_idle_done", 64'(done), 64'(0));

    // Fresh priority, then held contention: 0,1,2,3
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    acc_delay = 0;
    ser_len = 5;
    for (int unsigned r = 0; r < NR; r++) begin
      e.idx = r;
      exp_q.push_back(e);
    end
    req = 4'b1111;
    seen = 0;
    mask = '0;
    t = 0;
    while (seen < 4 && t < 2000) begin
      @(negedge clk);
      t++;
      if (done != '0) begin
        seen++;
        mask = mask | done;
      end
    end
    req = '0;
    chk("contention_done_count", 64'(seen), 64'(4));
    chk("contention_done_mask", 64'(mask), 64'(4'b1111));
    @(negedge clk);
    chk("contention_idle", 64'(grant), 64'(0));

    // Table-driven arbitration vectors
    for (int unsigned v = 0; v < 12; v++) begin
      acc_delay = tbl[v].acc;
      ser_len = tbl[v].ser;
      e.idx = tbl[v].exp_idx;
      exp_q.push_back(e);
      req = tbl[v].req;
      wait_grant("table");
      chk("table_grant", 64'(grant), 64'(onehot(tbl[v].exp_idx)));
      wait_done("table");
      chk("table_done", 64'(done), 64'(onehot(tbl[v].exp_idx)));
      req = '0;
      @(negedge clk);
    end

    // Encoder stall: ready held while the encoder does not accept
    acc_delay = 10;
    ser_len = 8;
    e.idx = 1;
    exp_q.push_back(e);
    req = 4'b0010;
    wait_grant("stall");
    g = grant;
    for (int unsigned c = 0; c < 11; c++) begin
      chk("stall_ready", 64'(enc_ready), 64'(1));
      chk("stall_busy", 64'(busy), 64'(1));
      chk("stall_grant", 64'(grant), 64'(g));
      chk("stall_done", 64'(done), 64'(0));
      @(negedge clk);
    end
    chk("stall_ready_after_accept", 64'(enc_ready), 64'(0));
    wait_done("stall");
    req = '0;
    @(negedge clk);

    // Dropped request during BUSY still completes
    acc_delay = 1;
    ser_len = 20;
    e.idx = 2;
    exp_q.push_back(e);
    req = 4'b0100;
    wait_grant("drop");
    wait_ready_low("drop");
    repeat (2) @(negedge clk);
    req = '0;
    wait_done("drop");
    chk("drop_done", 64'(done), 64'(4'b0100));
    @(negedge clk);
    chk("drop_grant_cleared", 64'(grant), 64'(0));
    chk("drop_busy_cleared", 64'(busy), 64'(0));

    // Mid-transfer reset: asynchronous clear, no done, priority restarts
    acc_delay = 0;
    ser_len = 30;
    e.idx = 3;
    exp_q.push_back(e);
    req = 4'b1000;
    wait_grant("midrst");
    wait_ready_low("midrst");
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    req = '0;
    #1;
    chk("midrst_grant", 64'(grant), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_enc_ready", 64'(enc_ready), 64'(0));
    chk("midrst_enc_matrix", 64'(enc_matrix[0][0][0]), 64'(0));
    for (int unsigned c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst_no_done", 64'(done), 64'(0));
    end
    req = 4'b0110;
    e.idx = 1;
    exp_q.push_back(e);
    rst_n = 1'b1;
    @(negedge clk);
    wait_grant("postrst");
    chk("postrst_grant", 64'(grant), 64'(4'b0010));
    wait_done("postrst");
    req = '0;
    @(negedge clk);

    // Two-requester fairness on the second instance
    req2 = 2'b11;
    for (int unsigned n = 0; n < 8; n++) begin
      t = 0;
      while (grant2 == '0 && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("fair_grant", 64'(grant2), 64'((n % 2 == 0) ? 2'b01 : 2'b10));
      chk_mat("fair_matrix", enc_matrix2, n % 2);
      t = 0;
      while (done2 == '0 && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("fair_done", 64'(done2), 64'((n % 2 == 0) ? 2'b01 : 2'b10));
      @(negedge clk);
    end
    req2 = '0;
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
